// File: rtl/dds_sweep_if.sv
// dds_sweep_if: configuration/control inputs and DDS-facing outputs of the sweep engine
interface dds_sweep_if #(
  parameter int DWELL_W = 24,
  parameter int STEPS_W = 16
);
  logic               cfg_valid;
  logic [31:0]        cfg_m_start;
  logic [31:0]        cfg_m_step;
  logic [STEPS_W-1:0] cfg_steps;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               start;
  logic               abort;
  logic [31:0]        m;
  logic               set;
  logic               en;
  logic               busy;
  logic               done;
  modport master (
    output cfg_valid, cfg_m_start, cfg_m_step, cfg_steps, cfg_dwell, start, abort,
    input  m, set, en, busy, done
  );
  modport slave (
    input  cfg_valid, cfg_m_start, cfg_m_step, cfg_steps, cfg_dwell, start, abort,
    output m, set, en, busy, done
  );
endinterface

// File: rtl/dds_sweep.sv
// dds_sweep: steps a DDS phase increment through a linear sweep, holding each tone for a dwell period
module dds_sweep #(
  parameter int DWELL_W = 24,
  parameter int STEPS_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  dds_sweep_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;
  state_t             state, state_nx;
  logic [31:0]        m_start_r, m_start_nx, m_step_r, m_step_nx, m_r, m_nx;
  logic [STEPS_W-1:0] steps_r, steps_nx, step_r, step_nx;
  logic [DWELL_W-1:0] dwell_r, dwell_nx, cnt_r, cnt_nx, dwell_last;
  logic               set_r, set_nx, en_r, en_nx, busy_r, busy_nx, done_r, done_nx;
  assign dwell_last = (dwell_r == '0) ? '0 : dwell_r - 1'b1;
  assign bus.m      = m_r;
  assign bus.set    = set_r;
  assign bus.en     = en_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  // next-state: config latch outside DWELL, then abort > start > dwell expiry
  always_comb begin
    state_nx   = state;
    m_start_nx = m_start_r;
    m_step_nx  = m_step_r;
    steps_nx   = steps_r;
    dwell_nx   = dwell_r;
    m_nx       = m_r;
    step_nx    = step_r;
    cnt_nx     = cnt_r;
    set_nx     = 1'b0;
    done_nx    = 1'b0;
    en_nx      = en_r;
    busy_nx    = busy_r;
    if (state != DWELL && bus.cfg_valid) begin
      m_start_nx = bus.cfg_m_start;
      m_step_nx  = bus.cfg_m_step;
      steps_nx   = bus.cfg_steps;
      dwell_nx   = bus.cfg_dwell;
    end
    if (bus.abort) begin
      state_nx = IDLE;
      en_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else if (state != DWELL && bus.start) begin
      state_nx = DWELL;
      m_nx     = m_start_nx;
      set_nx   = 1'b1;
      en_nx    = 1'b1;
      busy_nx  = 1'b1;
      step_nx  = '0;
      cnt_nx   = '0;
    end else if (state == DWELL && cnt_r == dwell_last) begin
      cnt_nx = '0;
      if (step_r < steps_r) begin
        m_nx    = m_r + m_step_r;
        set_nx  = 1'b1;
        step_nx = step_r + 1'b1;
      end else begin
        state_nx = HOLD;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
      end
    end else if (state == DWELL) begin
      cnt_nx = cnt_r + 1'b1;
    end
  end
  // state and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_start_r <= '0;
      m_step_r  <= '0;
      steps_r   <= '0;
      dwell_r   <= '0;
      m_r       <= '0;
      step_r    <= '0;
      cnt_r     <= '0;
      set_r     <= 1'b0;
      done_r    <= 1'b0;
      en_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      m_start_r <= m_start_nx;
      m_step_r  <= m_step_nx;
      steps_r   <= steps_nx;
      dwell_r   <= dwell_nx;
      m_r       <= m_nx;
      step_r    <= step_nx;
      cnt_r     <= cnt_nx;
      set_r     <= set_nx;
      done_r    <= done_nx;
      en_r      <= en_nx;
      busy_r    <= busy_nx;
    end
  end
endmodule

// File: doc/dds_sweep.md
DDS_SWEEP -- requirements
Module: dds_sweep

Interface
REQ-001 The module SHALL have parameter DWELL_W, default 24, which sets the width of the dwell-time counter in clk cycles.
REQ-002 The module SHALL have parameter STEPS_W, default 16, which sets the width of the step-count field.
REQ-003 clk  input  1  the single system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  the reset; it SHALL be asynchronous and active-low.
REQ-005 cfg_valid  input  1  a one-cycle strobe that loads the cfg_* inputs into internal registers.
REQ-006 cfg_m_start  input  32  the phase increment of the first tone.
REQ-007 cfg_m_step  input  32  the per-step phase-increment delta, treated as unsigned and added modulo 2^32.
REQ-008 cfg_steps  input  STEPS_W  the number of increments after the first tone.
REQ-009 cfg_dwell  input  DWELL_W  the number of clk cycles each tone is held.
REQ-010 start  input  1  a one-cycle strobe that begins a sweep.
REQ-011 abort  input  1  a one-cycle strobe that stops the sweep and disables the output.
REQ-012 m  output  32  the phase increment presented to the downstream DDS.
REQ-013 set  output  1  a one-cycle strobe telling the DDS to load m.
REQ-014 en  output  1  the DDS output enable.
REQ-015 busy  output  1  high while a sweep is in progress.
REQ-016 done  output  1  a one-cycle pulse at the end of a sweep.

Function
REQ-017 The state machine SHALL have exactly three states: IDLE, DWELL and HOLD.
REQ-018 In IDLE, cfg_valid SHALL latch all cfg_* inputs; in DWELL, cfg_valid SHALL be ignored.
REQ-019 In HOLD, cfg_valid SHALL latch all cfg_* inputs, and the new values SHALL only affect the next sweep.
REQ-020 When start is sampled in IDLE or HOLD at edge k, from edge k: m = latched m_start, set = 1 for one cycle, en = 1, busy = 1, the step counter = 0, and the state SHALL be DWELL.
REQ-021 When cfg_valid and start are high in the same cycle, the newly presented cfg values SHALL be used for that sweep.
REQ-022 start SHALL be ignored in DWELL.
REQ-023 Dwell period D = max(cfg_dwell, 1); consecutive set pulses SHALL be exactly D cycles apart, so a dwell of 0 is treated as 1.
REQ-024 At the end of each dwell, if the step counter < steps: m SHALL become m + m_step (mod 2^32, carry discarded), set SHALL pulse, and the step counter SHALL increment.
REQ-025 At the end of the dwell that follows the last tone (step counter == steps): done SHALL pulse for one cycle, busy SHALL go to 0, the state SHALL be HOLD, and no set pulse SHALL be issued.
REQ-026 In HOLD, en SHALL remain 1 and m SHALL keep the final value, so the final tone continues.
REQ-027 With cfg_steps = 0, the sweep SHALL produce one set pulse and one done pulse D cycles later.
REQ-028 A sweep SHALL produce exactly steps + 1 set pulses in total.
REQ-029 An abort in any state SHALL give, from the next edge: en = 0, busy = 0, state IDLE, no set pulse and no done pulse, with m unchanged.
REQ-030 abort SHALL take priority over start and over a dwell expiry in the same cycle.
REQ-031 An abort in IDLE SHALL have no effect other than keeping en at 0.
REQ-032 set and done SHALL never be high in the same cycle.
REQ-033 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-034 While rst_n = 0: m = 0, set = 0, en = 0, busy = 0, done = 0, state = IDLE, and all latched cfg registers and counters = 0.
REQ-035 When rst_n is asserted mid-sweep, the module SHALL return to the reset state immediately, with no set or done pulse.
REQ-036 After rst_n is released, start with no prior cfg_valid SHALL sweep using the all-zero configuration: m = 0, one set pulse, done one cycle later.

Verification
REQ-037 Basic sweep: cfg m_start=1000, m_step=250, steps=3, dwell=4, then start -> m = 1000, 1250, 1500, 1750 with set at cycles 0, 4, 8, 12; done at cycle 16; en stays 1 and m=1750 afterwards.
REQ-038 Wrap: m_start=0xFFFFFF00, m_step=0x200, steps=1, dwell=2 -> m = 0xFFFFFF00, then 0x00000100.
REQ-039 Dwell 0: steps=2, dwell=0 -> set pulses on 3 consecutive cycles; done on the following cycle.
REQ-040 Abort at cycle 5 of REQ-037 -> en = 0 and busy = 0 next cycle; no further set pulses and no done pulse; m = 1250 is held.
REQ-041 Ignored inputs: start and cfg_valid(m_start=7) during DWELL -> the sweep continues unchanged; a later start from IDLE still uses the original cfg.
REQ-042 Reset mid-sweep: rst_n low at cycle 6 -> all outputs are 0 asynchronously, before the next clk edge.
